// File: rtl/fpu_pkg.sv
// fpu_pkg: shared binary32 types, constants
// and the stage bundles of the add/sub pipe.
package fpu_pkg;

  localparam int          EXP_BIAS = 127;
  localparam logic [7:0]  EXP_MAX  = 8'hFF;
  localparam logic [31:0] QNAN     = 32'h7FC00000;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp32_t;

  typedef struct packed {
    logic invalid;
    logic overflow;
    logic underflow;
    logic inexact;
  } fp_flags_t;

  typedef struct packed {
    logic        sx;
    logic        sy;
    logic        sub;
    logic [7:0]  ex;
    logic [26:0] mx;
    logic [26:0] my;
    logic        nan;
    logic        inf;
    logic        inf_s;
  } s1_t;

  typedef struct packed {
    logic        sx;
    logic        zs;
    logic [7:0]  ex;
    logic [27:0] sum;
    logic        nan;
    logic        inf;
    logic        inf_s;
  } s2_t;

  function automatic logic [4:0] lzc27(
    input logic [26:0] v
  );
    logic [4:0] n;
    logic       hit;
    n   = 5'd27;
    hit = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!hit && v[i]) begin
        n   = 5'(26 - i);
        hit = 1'b1;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/fp32_norm_round.sv
// fp32_norm_round: S3 combinational logic --
// normalize, round-to-nearest-even, pack, specials.
module fp32_norm_round
  import fpu_pkg::*;
(
  input  s2_t         i_s2,
  output logic [31:0] o_res,
  output fp_flags_t   o_flags
);

  logic [4:0]  w_lz;
  logic [26:0] w_m;
  logic [9:0]  w_e;
  logic [9:0]  w_e2;
  logic        w_g;
  logic        w_r;
  logic        w_s;
  logic        w_up;
  logic        w_c;
  logic [22:0] w_f;

  assign w_lz = lzc27(i_s2.sum[26:0]);

  // carry-out shifts right, otherwise shift out leading zeros
  always_comb begin
    w_m = '0;
    w_e = '0;
    if (i_s2.sum[27]) begin
      w_m = {i_s2.sum[27:2], i_s2.sum[1] | i_s2.sum[0]};
      w_e = {2'b00, i_s2.ex} + 10'd1;
    end else begin
      w_m = i_s2.sum[26:0] << w_lz;
      w_e = {2'b00, i_s2.ex} - {5'd0, w_lz};
    end
  end

  assign w_g  = w_m[2];
  assign w_r  = w_m[1];
  assign w_s  = w_m[0];
  assign w_up = w_g & (w_r | w_s | w_m[3]);
  assign {w_c, w_f} = {1'b0, w_m[25:3]} + {23'd0, w_up};
  assign w_e2 = w_e + {9'd0, w_c};

  // result selection, specials take priority
  always_comb begin
    o_res   = '0;
    o_flags = '0;
    if (i_s2.nan) begin
      o_res           = QNAN;
      o_flags.invalid = 1'b1;
    end else if (i_s2.inf) begin
      o_res = {i_s2.inf_s, EXP_MAX, 23'd0};
    end else if (!w_m[26]) begin
      o_res = {i_s2.zs, 31'd0};
    end else if (w_e[9] || (w_e == 10'd0)) begin
      o_res             = {i_s2.sx, 31'd0};
      o_flags.underflow = 1'b1;
      o_flags.inexact   = 1'b1;
    end else if (!w_e2[9] && (w_e2 >= 10'd255)) begin
      o_res            = {i_s2.sx, EXP_MAX, 23'd0};
      o_flags.overflow = 1'b1;
      o_flags.inexact  = 1'b1;
    end else begin
      o_res           = {i_s2.sx, w_e2[7:0], w_f};
      o_flags.inexact = w_g | w_r | w_s;
    end
  end

endmodule

// File: rtl/fp32_addsub_pipe.sv
// fp32_addsub_pipe: three-stage binary32 add/sub,
// align -> add -> normalize/round, with backpressure.
module fp32_addsub_pipe
  import fpu_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic             in_sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_res,
  output logic [3:0]       out_flags,
  output logic [TAG_W-1:0] out_tag
);

  fp32_t       w_a;
  fp32_t       w_b;
  logic        w_sb;
  logic        w_nan_a;
  logic        w_nan_b;
  logic        w_inf_a;
  logic        w_inf_b;
  logic        w_swap;
  logic [22:0] w_fa;
  logic [22:0] w_fb;
  logic [22:0] w_fx;
  logic [22:0] w_fy;
  logic [7:0]  w_ex;
  logic [7:0]  w_ey;
  logic [7:0]  w_diff;
  logic        w_sx;
  logic        w_sy;
  logic [4:0]  w_sh;
  logic [57:0] w_wide;
  s1_t         w_s1;
  s2_t         w_s2;
  logic [31:0] w_res;
  fp_flags_t   w_flags;
  logic        w_stall;

  s1_t              r_s1;
  logic             r_v1;
  logic [TAG_W-1:0] r_t1;
  s2_t              r_s2;
  logic             r_v2;
  logic [TAG_W-1:0] r_t2;
  logic [31:0]      r_res;
  fp_flags_t        r_flags;
  logic             r_v3;
  logic [TAG_W-1:0] r_t3;

  assign w_stall  = r_v3 & ~out_ready;
  assign in_ready = ~w_stall;

  assign w_a     = in_a;
  assign w_b     = in_b;
  assign w_sb    = w_b.sign ^ in_sub;
  assign w_nan_a = (w_a.exp == EXP_MAX) && (w_a.frac != 23'd0);
  assign w_nan_b = (w_b.exp == EXP_MAX) && (w_b.frac != 23'd0);
  assign w_inf_a = (w_a.exp == EXP_MAX) && (w_a.frac == 23'd0);
  assign w_inf_b = (w_b.exp == EXP_MAX) && (w_b.frac == 23'd0);
  assign w_fa    = (w_a.exp == 8'd0) ? 23'd0 : w_a.frac;
  assign w_fb    = (w_b.exp == 8'd0) ? 23'd0 : w_b.frac;
  assign w_swap  = {w_b.exp, w_fb} > {w_a.exp, w_fa};
  assign w_ex    = w_swap ? w_b.exp : w_a.exp;
  assign w_ey    = w_swap ? w_a.exp : w_b.exp;
  assign w_fx    = w_swap ? w_fb : w_fa;
  assign w_fy    = w_swap ? w_fa : w_fb;
  assign w_sx    = w_swap ? w_sb : w_a.sign;
  assign w_sy    = w_swap ? w_a.sign : w_sb;
  assign w_diff  = w_ex - w_ey;
  assign w_sh    = (w_diff > 8'd31) ? 5'd31 : w_diff[4:0];
  assign w_wide  = {w_ey != 8'd0, w_fy, 3'b000, 31'd0} >> w_sh;

  // S1 align bundle: larger magnitude is X, Y shifted with sticky
  always_comb begin
    w_s1       = '0;
    w_s1.sx    = w_sx;
    w_s1.sy    = w_sy;
    w_s1.sub   = w_sx ^ w_sy;
    w_s1.ex    = w_ex;
    w_s1.mx    = {w_ex != 8'd0, w_fx, 3'b000};
    w_s1.my    = {w_wide[57:32], |w_wide[31:0]};
    w_s1.nan   = w_nan_a | w_nan_b
               | (w_inf_a & w_inf_b & (w_a.sign ^ w_sb));
    w_s1.inf   = w_inf_a | w_inf_b;
    w_s1.inf_s = w_inf_a ? w_a.sign : w_sb;
  end

  // S2 magnitude add/sub; X >= Y so never negative
  always_comb begin
    w_s2       = '0;
    w_s2.sx    = r_s1.sx;
    w_s2.zs    = r_s1.sx & r_s1.sy;
    w_s2.ex    = r_s1.ex;
    w_s2.sum   = r_s1.sub
               ? ({1'b0, r_s1.mx} + ~{1'b0, r_s1.my} + 28'd1)
               : ({1'b0, r_s1.mx} + {1'b0, r_s1.my});
    w_s2.nan   = r_s1.nan;
    w_s2.inf   = r_s1.inf;
    w_s2.inf_s = r_s1.inf_s;
  end

  fp32_norm_round u_nr (
    .i_s2    (r_s2),
    .o_res   (w_res),
    .o_flags (w_flags)
  );

  // S1 register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1 <= 1'b0;
      r_s1 <= '0;
      r_t1 <= '0;
    end else if (!w_stall) begin
      r_v1 <= in_valid;
      r_s1 <= w_s1;
      r_t1 <= in_tag;
    end
  end

  // S2 register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v2 <= 1'b0;
      r_s2 <= '0;
      r_t2 <= '0;
    end else if (!w_stall) begin
      r_v2 <= r_v1;
      r_s2 <= w_s2;
      r_t2 <= r_t1;
    end
  end

  // S3 output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v3    <= 1'b0;
      r_res   <= '0;
      r_flags <= '0;
      r_t3    <= '0;
    end else if (!w_stall) begin
      r_v3    <= r_v2;
      r_res   <= w_res;
      r_flags <= w_flags;
      r_t3    <= r_t2;
    end
  end

  assign out_valid = r_v3;
  assign out_res   = r_res;
  assign out_flags = r_flags;
  assign out_tag   = r_t3;

endmodule

// File: doc/fp32_addsub_pipe.md
# fp32_addsub_pipe

Three-stage pipelined IEEE-754 single-precision adder/subtractor: the FFT butterfly datapath's add/sub operator. It consumes the team's FPU primitives: 28-bit CLA, right/left barrel shifters, 32-bit LZC, 8/23-bit incrementers and 24-bit compare. It produces round-to-nearest-even results at one operation per clock, with a valid/ready handshake and a sideband tag that carries butterfly index information.

## Interface
- `TAG_W`, default 4: width of the sideband tag that passes through the pipe unchanged.
- `clk`  in  1: sole clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: operand beat present.
- `in_ready`  out  1: the block accepts a beat when `in_valid & in_ready`.
- `in_a`, `in_b`  in  32 each: IEEE-754 binary32 operands.
- `in_sub`  in  1: 1 computes a−b, 0 computes a+b.
- `in_tag`  in  TAG_W: sideband, returned with the result.
- `out_valid`  out  1: result present.
- `out_ready`  in  1: the consumer accepts a result when `out_valid & out_ready`.
- `out_res`  out  32: binary32 result.
- `out_flags`  out  4: {invalid, overflow, underflow, inexact}.
- `out_tag`  out  TAG_W: the tag of the result.

## Operation
- Effective sign of b = `in_b[31] ^ in_sub`.
- Denormal inputs are flushed to signed zero (FTZ).
- **S1, align**
  - Compare {exp, mant}; swap so the larger magnitude is X.
  - Diff = expX − expY, computed with the 8-bit subtractor.
  - Shift amount = min(diff, 31).
  - Y is extended to 27 bits {hidden, 23 frac, G, R, S=0} and right-shifted. Sticky = OR of every bit shifted below R.
  - Special-case detect: NaN, inf, zero.
- **S2, add.** A 28-bit CLA adds or subtracts the magnitudes. Subtraction is X + ~Y + 1. The result is never negative because X ≥ Y.
- **S3, normalize/round/pack**
  - Carry-out: right-shift by 1, exp+1, sticky absorbs the lost bit.
  - Otherwise: LZC, left-shift by count, exp−count.
  - Round to nearest even using G/R/S, via the 23-bit incrementer. A mantissa overflow from rounding increments the exponent.
- Special results:
  - NaN operand, or inf−inf: 0x7FC00000 with invalid set. Input NaN payloads are not propagated.
  - Inf operand otherwise: that inf, no flags.
  - Exponent ≥ 255 after rounding: ±inf with overflow and inexact set.
  - Exponent ≤ 0 after normalization: signed zero with underflow set; inexact set if the magnitude was nonzero.
  - Exact cancellation: +0. (−0)+(−0) = −0.
- Inexact is set when G|R|S ≠ 0 before rounding, and on overflow/underflow.

## Timing
- Latency is exactly 3 accepted clocks from input handshake to `out_valid`. Throughput is 1 per clock.
- Stall rule: `stall = out_valid & ~out_ready`; `in_ready = ~stall`.
- While stalled, all three stage registers, including valid bits, hold. Nothing is dropped or duplicated, and order is preserved.
- Bubbles are not collapsed during a stall. That is acceptable.
- `out_*` is stable while `out_valid & ~out_ready`.
- Reset clears all stage valid bits asynchronously. Reset values:
  - `out_valid` = 0, `out_res` = 0, `out_flags` = 0, `out_tag` = 0.
  - `in_ready` = 1.
  - Data registers of the other stages reset to 0.
- Reset mid-stream discards in-flight operations. The first result after reset release belongs to the first beat accepted after release.
- `in_valid` with `in_ready` = 0 is not accepted. The source holds its beat.

## Structure
- `fpu_pkg` holds the shared definitions:
  - `fp32_t` struct {sign, exp[7:0], frac[22:0]}.
  - `EXP_BIAS` = 127, `EXP_MAX` = 8'hFF, `QNAN` = 32'h7FC00000.
  - `fp_flags_t` struct {invalid, overflow, underflow, inexact}.
- Each stage is a registered always_ff block with enable `~stall`.
- One sub-module, `fp32_norm_round`, holds the S3 combinational logic: LZC, left shift, RNE, pack, specials. The pipe top instantiates it between the S2 and S3 registers.

## Test plan
- Basic add: 0x3F800000 + 0x3F800000, `in_sub` = 0, tag 5 → after 3 clocks 0x40000000, flags 0, tag 5.
- Cancellation: 0x3F800000 − 0x3F800000 → 0x00000000, flags 0. Also 0x80000000 + 0x80000000 → 0x80000000.
- Round-to-even tie and overflow:
  - 0x3F800000 + 0x33800000 → 0x3F800000 with inexact.
  - 0x3F800001 + 0x33800000 → 0x3F800002 with inexact.
  - 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000 with overflow and inexact.
- Specials:
  - 0x7F800000 + 0xFF800000 → 0x7FC00000 with invalid.
  - 0x7FC00001 + 0x3F800000 → 0x7FC00000 with invalid.
  - 0x00000001 (denormal) + 0x00000000 → 0x00000000.
- Backpressure: 16 random back-to-back beats with tags 0..15 while `out_ready` follows a random 50% pattern → all 16 results arrive in tag order and match the golden model. `in_ready` is low exactly on the stall cycles.
- Reset mid-stream: 3 beats in flight, assert `rst_n` = 0 for 1 clock → `out_valid` drops immediately. After release, a new beat 0x40400000 + 0xC0000000 yields 0x3F800000 as the first result.
